// File: rtl/alu_arbiter_pkg.sv
// Shared opcode map and FSM encoding for the two-requester ALU arbiter.
package alu_arbiter_pkg;

   localparam logic [2:0] OP_NOT = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_XOR = 3'b010;
   localparam logic [2:0] OP_AND = 3'b011;
   localparam logic [2:0] OP_MUL = 3'b100;
   localparam logic [2:0] OP_ADD = 3'b101;
   localparam logic [2:0] OP_SUB = 3'b110;
   localparam logic [2:0] OP_NOP = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_e;

endpackage

// File: rtl/alu_arbiter_alu_core.sv
// Purely combinational 8-bit ALU; results are truncated to DATA_W bits, no flags.
module alu_core
   import alu_arbiter_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic [2:0]        op_i,
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   output logic [DATA_W-1:0] y_o
);

   always_comb begin
      y_o = '0;
      case (op_i)
         OP_NOT:  y_o = ~a_i;
         OP_OR:   y_o = a_i | b_i;
         OP_XOR:  y_o = a_i ^ b_i;
         OP_AND:  y_o = a_i & b_i;
         OP_MUL:  y_o = a_i * b_i;
         OP_ADD:  y_o = a_i + b_i;
         OP_SUB:  y_o = a_i - b_i;
         default: y_o = '0;
      endcase
   end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two valid/ready command ports,
// with a multi-cycle MUL and a registered valid/ready response port.
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int MUL_LAT = 3,
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [2:0]        req0_op,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [2:0]        req1_op,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_id,
   output logic [DATA_W-1:0] rsp_data,
   output logic              busy,
   output logic [CNT_W-1:0]  done_cnt
);

   if (DATA_W != 8) begin : g_bad_data_w
      $error("alu_arbiter: DATA_W must be 8");
   end
   if (MUL_LAT < 1 || MUL_LAT > 8) begin : g_bad_mul_lat
      $error("alu_arbiter: MUL_LAT must be in 1..8");
   end

   // EXEC runs cnt+1 cycles, so MUL loads MUL_LAT-1 and everything else loads 0.
   localparam logic [2:0] MUL_CNT = 3'(MUL_LAT - 1);

   state_e            state_q, state_d;
   logic              rr_q, rr_d;
   logic [2:0]        op_q, op_d;
   logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
   logic              id_q, id_d;
   logic [2:0]        cnt_q, cnt_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_id_q, rsp_id_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic [CNT_W-1:0]  done_q, done_d;
   logic              grant, idle, accept;
   logic [DATA_W-1:0] alu_y;

   assign grant      = (req0_valid && req1_valid) ? rr_q : req1_valid;
   assign idle       = (state_q == ST_IDLE);
   assign req0_ready = idle && req0_valid && !grant;
   assign req1_ready = idle && req1_valid && grant;
   assign accept     = req0_ready || req1_ready;

   alu_core #(.DATA_W(DATA_W)) u_alu (
      .op_i (op_q),
      .a_i  (a_q),
      .b_i  (b_q),
      .y_o  (alu_y)
   );

   always_comb begin
      state_d     = state_q;
      rr_d        = rr_q;
      op_d        = op_q;
      a_d         = a_q;
      b_d         = b_q;
      id_d        = id_q;
      cnt_d       = cnt_q;
      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      rsp_data_d  = rsp_data_q;
      done_d      = done_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               op_d    = grant ? req1_op : req0_op;
               a_d     = grant ? req1_a  : req0_a;
               b_d     = grant ? req1_b  : req0_b;
               id_d    = grant;
               cnt_d   = ((grant ? req1_op : req0_op) == OP_MUL) ? MUL_CNT : 3'd0;
               rr_d    = ~grant;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (cnt_q == 3'd0) begin
               rsp_data_d  = alu_y;
               rsp_id_d    = id_q;
               rsp_valid_d = 1'b1;
               state_d     = ST_RESP;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               done_d      = done_q + CNT_W'(1);
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         rr_q        <= 1'b0;
         op_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         id_q        <= 1'b0;
         cnt_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_data_q  <= '0;
         done_q      <= '0;
      end else begin
         state_q     <= state_d;
         rr_q        <= rr_d;
         op_q        <= op_d;
         a_q         <= a_d;
         b_q         <= b_d;
         id_q        <= id_d;
         cnt_q       <= cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_data_q  <= rsp_data_d;
         done_q      <= done_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;
   assign busy      = (state_q != ST_IDLE);
   assign done_cnt  = done_q;

endmodule
